// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the device1 UART transmitter.
// State and word-length encodings plus the line idle level.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    BITS5,
    BITS6,
    BITS7,
    BITS8
  } data_bits_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Number of data bits carried by a frame for a given word-length code.
  function automatic logic [3:0] word_len(input data_bits_e db);
    return 4'(db) + 4'd5;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled.
// Pulses bit_tick on the terminal count.
module uart_baud_counter #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (enable) begin
      cnt_next = (cnt_reg == TERMINAL) ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign bit_tick = enable && (cnt_reg == TERMINAL);

endmodule

// File: rtl/device1_uart_tx.sv
// UART transmitter: accepts a byte over valid/ready and serializes it as
// start, 5-8 data bits LSB first, optional parity, then 1 or 2 stop bits.
module device1_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int BAUD_DIV      = 16,
  parameter int MAX_DATA_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [MAX_DATA_BITS-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [1:0]               data_bits,
  input  logic                     parity_en,
  input  logic                     parity_odd,
  input  logic                     stop_two,
  output logic                     tx,
  output logic                     busy,
  output logic                     tx_done
);

  tx_state_e                state_reg, state_next;
  logic [MAX_DATA_BITS-1:0] shift_reg, shift_next;
  logic [2:0]               bit_idx_reg, bit_idx_next;
  logic                     stop_cnt_reg, stop_cnt_next;
  data_bits_e               data_bits_reg;
  logic                     parity_en_reg;
  logic                     parity_reg;
  logic                     stop_two_reg;
  logic                     tx_reg, tx_next;
  logic                     busy_reg, busy_next;
  logic                     done_reg, done_next;

  logic                     accept;
  logic                     bit_tick;
  logic                     last_data_bit;
  logic [MAX_DATA_BITS-1:0] data_masked;
  logic                     parity_calc;

  assign tx_ready = (state_reg == IDLE);
  assign accept   = tx_valid && tx_ready;

  // Only the bits that will actually be sent contribute to parity.
  generate
    for (genvar gi = 0; gi < MAX_DATA_BITS; gi++) begin : g_mask
      assign data_masked[gi] = tx_data[gi] && (4'(gi) < word_len(data_bits_e'(data_bits)));
    end
  endgenerate

  assign parity_calc   = (^data_masked) ^ parity_odd;
  assign last_data_bit = (bit_idx_reg == 3'(word_len(data_bits_reg) - 4'd1));

  uart_baud_counter #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .enable   (state_reg != IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tx_valid) state_next = START;
      START:   if (bit_tick) state_next = DATA;
      DATA:    if (bit_tick && last_data_bit) state_next = parity_en_reg ? PARITY : STOP;
      PARITY:  if (bit_tick) state_next = STOP;
      STOP:    if (bit_tick && (stop_cnt_reg == stop_two_reg)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    stop_cnt_next = stop_cnt_reg;
    if (accept) begin
      shift_next    = tx_data;
      bit_idx_next  = '0;
      stop_cnt_next = 1'b0;
    end else if (bit_tick) begin
      if (state_reg == DATA) begin
        shift_next   = shift_reg >> 1;
        bit_idx_next = bit_idx_reg + 3'd1;
      end
      if (state_reg == STOP) begin
        stop_cnt_next = 1'b1;
      end
    end
  end

  // Outputs are registered from the upcoming state so the line changes
  // on the same edge the state does.
  always_comb begin
    tx_next = UART_IDLE_LEVEL;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_reg;
      default: tx_next = UART_IDLE_LEVEL;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_reg == STOP) && (state_next == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg     <= '0;
      bit_idx_reg   <= '0;
      stop_cnt_reg  <= 1'b0;
      data_bits_reg <= BITS8;
      parity_en_reg <= 1'b0;
      parity_reg    <= 1'b0;
      stop_two_reg  <= 1'b0;
      tx_reg        <= UART_IDLE_LEVEL;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      stop_cnt_reg <= stop_cnt_next;
      if (accept) begin
        data_bits_reg <= data_bits_e'(data_bits);
        parity_en_reg <= parity_en;
        parity_reg    <= parity_calc;
        stop_two_reg  <= stop_two;
      end
      tx_reg   <= tx_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  assign tx      = tx_reg;
  assign busy    = busy_reg;
  assign tx_done = done_reg;

endmodule
